// File: rtl/ad9434_sample_pack.sv
// AD9434 sample packer: registers the DDR lanes, formats 12-bit samples into 16-bit lanes,
// packs four lanes per 64-bit word and streams a length-bounded capture through a 2-entry buffer.
`timescale 1ns/1ps

module ad9434_sample_pack #(
    parameter string DATA_FORMAT = "OFFSET",
    parameter int    LANE_SWAP   = 0,
    parameter int    LEN_W       = 16
) (
    input  logic             adc_clk,
    input  logic             rst,
    input  logic [5:0]       din_q1,
    input  logic [5:0]       din_q2,
    input  logic             din_or,
    input  logic             capture_start,
    input  logic [LEN_W-1:0] capture_len,
    output logic [63:0]      m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [LEN_W-1:0] overflow_cnt
);

    localparam bit IS_TWOS = (DATA_FORMAT == "TWOS");
    localparam bit SWAP    = (LANE_SWAP != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic        last;
        logic [63:0] data;
    } entry_t;

    // Input and format pipeline
    logic [5:0]       din_q1_q, din_q2_q;
    logic             din_or_q;
    logic             in_vld_q, in_vld_d;
    logic [15:0]      fmt_q, fmt_d;
    logic             fmt_vld_q, fmt_vld_d;

    // Packing state machine
    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] word_cnt_q, word_cnt_d;
    logic [1:0]       slot_q, slot_d;
    logic [47:0]      acc_q, acc_d;
    logic             done_q, done_d;
    logic             overflow_q, overflow_d;
    logic [LEN_W-1:0] overflow_cnt_q, overflow_cnt_d;

    // Output buffer
    entry_t           fifo_q [2];
    entry_t           fifo_d [2];
    logic [1:0]       fifo_cnt_q, fifo_cnt_d;

    logic [11:0]      raw;
    logic [11:0]      smp;
    logic             word_wr;
    entry_t           word;
    logic             pop;

    always_comb begin
        raw       = SWAP ? {din_q2_q, din_q1_q} : {din_q1_q, din_q2_q};
        smp       = IS_TWOS ? {~raw[11], raw[10:0]} : raw;
        fmt_d     = {din_or_q, (IS_TWOS ? {3{smp[11]}} : 3'b000), smp};
        // A sample is tagged valid only if it was registered after the start edge,
        // so the two-stage pipeline never leaks pre-start data into a word.
        in_vld_d  = (state_q == S_CAPTURE);
        fmt_vld_d = in_vld_q;
    end

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        word_cnt_d     = word_cnt_q;
        slot_d         = slot_q;
        acc_d          = acc_q;
        done_d         = 1'b0;
        overflow_d     = overflow_q;
        overflow_cnt_d = overflow_cnt_q;
        fifo_d         = fifo_q;
        fifo_cnt_d     = fifo_cnt_q;
        word_wr        = 1'b0;
        word           = '{last: 1'b0, data: {fmt_q, acc_q}};
        pop            = (fifo_cnt_q != 2'd0) && m_tready;

        case (state_q)
            S_IDLE: begin
                if (capture_start && (capture_len != '0)) begin
                    len_d          = capture_len;
                    overflow_d     = 1'b0;
                    overflow_cnt_d = '0;
                    slot_d         = 2'd0;
                    word_cnt_d     = '0;
                    state_d        = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (fmt_vld_q) begin
                    if (slot_q == 2'd3) begin
                        word_wr    = 1'b1;
                        word_cnt_d = word_cnt_q + 1'b1;
                        slot_d     = 2'd0;
                        if (word_cnt_d == len_q) begin
                            word.last = 1'b1;
                            state_d   = S_DRAIN;
                        end
                    end else begin
                        acc_d[{slot_q, 4'b0000} +: 16] = fmt_q;
                        slot_d = slot_q + 2'd1;
                    end
                end
            end
            S_DRAIN: begin
                if ((fifo_cnt_q == 2'd0) || ((fifo_cnt_q == 2'd1) && m_tready)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (fifo_cnt_q)
            2'd0: begin
                if (word_wr) begin
                    fifo_d[0]  = word;
                    fifo_cnt_d = 2'd1;
                end
            end
            2'd1: begin
                if (pop && word_wr) begin
                    fifo_d[0] = word;
                end else if (pop) begin
                    fifo_cnt_d = 2'd0;
                end else if (word_wr) begin
                    fifo_d[1]  = word;
                    fifo_cnt_d = 2'd2;
                end
            end
            default: begin
                if (pop) begin
                    fifo_d[0] = fifo_q[1];
                    if (word_wr) begin
                        fifo_d[1] = word;
                    end else begin
                        fifo_cnt_d = 2'd1;
                    end
                end else if (word_wr) begin
                    overflow_d = 1'b1;
                    if (overflow_cnt_q != '1) begin
                        overflow_cnt_d = overflow_cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            din_q1_q       <= '0;
            din_q2_q       <= '0;
            din_or_q       <= 1'b0;
            in_vld_q       <= 1'b0;
            fmt_q          <= '0;
            fmt_vld_q      <= 1'b0;
            state_q        <= S_IDLE;
            len_q          <= '0;
            word_cnt_q     <= '0;
            slot_q         <= 2'd0;
            acc_q          <= '0;
            done_q         <= 1'b0;
            overflow_q     <= 1'b0;
            overflow_cnt_q <= '0;
            // NOTE: buffer storage is reset because the head entry drives m_tdata,
            // whose reset value is observable downstream.
            fifo_q[0]      <= '0;
            fifo_q[1]      <= '0;
            fifo_cnt_q     <= 2'd0;
        end else begin
            din_q1_q       <= din_q1;
            din_q2_q       <= din_q2;
            din_or_q       <= din_or;
            in_vld_q       <= in_vld_d;
            fmt_q          <= fmt_d;
            fmt_vld_q      <= fmt_vld_d;
            state_q        <= state_d;
            len_q          <= len_d;
            word_cnt_q     <= word_cnt_d;
            slot_q         <= slot_d;
            acc_q          <= acc_d;
            done_q         <= done_d;
            overflow_q     <= overflow_d;
            overflow_cnt_q <= overflow_cnt_d;
            fifo_q         <= fifo_d;
            fifo_cnt_q     <= fifo_cnt_d;
        end
    end

    assign m_tdata      = fifo_q[0].data;
    assign m_tlast      = fifo_q[0].last;
    assign m_tvalid     = (fifo_cnt_q != 2'd0);
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign overflow     = overflow_q;
    assign overflow_cnt = overflow_cnt_q;

endmodule

// File: tb/tb_ad9434_sample_pack.sv
// Self-checking bench for ad9434_sample_pack: table-driven format/alignment vectors on three
// parameter variants, plus hand-written back-pressure, reset, re-start and zero-length sequences.
`timescale 1ns/1ps

module tb_ad9434_sample_pack;

    logic        adc_clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  din_q1 = '0;
    logic [5:0]  din_q2 = '0;
    logic        din_or = 1'b0;
    logic        capture_start = 1'b0;
    logic [15:0] capture_len = '0;
    logic        m_tready = 1'b0;

    logic [63:0] m_tdata, tw_tdata, of_tdata;
    logic        m_tvalid, tw_tvalid, of_tvalid;
    logic        m_tlast, tw_tlast, of_tlast;
    logic        busy, tw_busy, of_busy;
    logic        done, tw_done, of_done;
    logic        overflow, tw_overflow, of_overflow;
    logic [15:0] overflow_cnt, tw_overflow_cnt, of_overflow_cnt;

    int checks = 0;
    int errors = 0;

    always #5 adc_clk = ~adc_clk;

    ad9434_sample_pack u_dut (
        .adc_clk(adc_clk), .rst(rst), .din_q1(din_q1), .din_q2(din_q2), .din_or(din_or),
        .capture_start(capture_start), .capture_len(capture_len),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .busy(busy), .done(done), .overflow(overflow), .overflow_cnt(overflow_cnt)
    );

    ad9434_sample_pack #(.DATA_FORMAT("TWOS"), .LANE_SWAP(1)) u_tw (
        .adc_clk(adc_clk), .rst(rst), .din_q1(din_q1), .din_q2(din_q2), .din_or(din_or),
        .capture_start(capture_start), .capture_len(capture_len),
        .m_tdata(tw_tdata), .m_tvalid(tw_tvalid), .m_tready(m_tready), .m_tlast(tw_tlast),
        .busy(tw_busy), .done(tw_done), .overflow(tw_overflow), .overflow_cnt(tw_overflow_cnt)
    );

    ad9434_sample_pack #(.DATA_FORMAT("OFFSET"), .LANE_SWAP(1)) u_of (
        .adc_clk(adc_clk), .rst(rst), .din_q1(din_q1), .din_q2(din_q2), .din_or(din_or),
        .capture_start(capture_start), .capture_len(capture_len),
        .m_tdata(of_tdata), .m_tvalid(of_tvalid), .m_tready(m_tready), .m_tlast(of_tlast),
        .busy(of_busy), .done(of_done), .overflow(of_overflow), .overflow_cnt(of_overflow_cnt)
    );

    // Stream monitor on the default-parameter instance
    int          cyc = 0;
    int          acc_words = 0;
    int          tlast_seen = 0;
    int          done_seen = 0;
    int          done_busy = 0;
    int          last_acc_cyc = 0;
    int          acc_gap = 0;
    logic [63:0] last_word = '0;
    logic        last_tlast = 1'b0;

    always @(posedge adc_clk) begin
        cyc <= cyc + 1;
        if (m_tvalid && m_tready) begin
            acc_words    <= acc_words + 1;
            last_word    <= m_tdata;
            last_tlast   <= m_tlast;
            acc_gap      <= cyc - last_acc_cyc;
            last_acc_cyc <= cyc;
            if (m_tlast) tlast_seen <= tlast_seen + 1;
        end
        if (done) begin
            done_seen <= done_seen + 1;
            if (busy) done_busy <= done_busy + 1;
        end
    end

    typedef struct {
        logic [5:0]  q1;
        logic [5:0]  q2;
        logic        orf;
        logic [15:0] e_main;
        logic [15:0] e_tw;
        logic [15:0] e_of;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge adc_clk);
        #1;
    endtask

    task automatic start_cap(input logic [15:0] len);
        capture_len   = len;
        capture_start = 1'b1;
        tick();
        capture_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        check({name, "_done"}, done, 1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_tvalid"}, m_tvalid, 0);
        check({name, "_tdata"}, m_tdata, 0);
        check({name, "_tlast"}, m_tlast, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_done"}, done, 0);
        check({name, "_overflow"}, overflow, 0);
        check({name, "_ovf_cnt"}, overflow_cnt, 0);
    endtask

    function automatic logic [63:0] rep4(input logic [15:0] l);
        return {l, l, l, l};
    endfunction

    initial begin
        int w0, t0, d0, n;

        vecs[0] = '{q1: 6'h2A, q2: 6'h15, orf: 1'b0, e_main: 16'h0A95, e_tw: 16'h7D6A, e_of: 16'h056A};
        vecs[1] = '{q1: 6'h00, q2: 6'h3F, orf: 1'b1, e_main: 16'h803F, e_tw: 16'h87C0, e_of: 16'h8FC0};
        vecs[2] = '{q1: 6'h3F, q2: 6'h3F, orf: 1'b0, e_main: 16'h0FFF, e_tw: 16'h07FF, e_of: 16'h0FFF};
        vecs[3] = '{q1: 6'h20, q2: 6'h00, orf: 1'b0, e_main: 16'h0800, e_tw: 16'h7820, e_of: 16'h0020};
        vecs[4] = '{q1: 6'h01, q2: 6'h3E, orf: 1'b1, e_main: 16'h807E, e_tw: 16'h8781, e_of: 16'h8F81};

        rst = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Format, swap, alignment and latency: inputs differ before the start edge
        for (int i = 0; i < 5; i++) begin
            m_tready = 1'b0;
            din_q1 = ~vecs[i].q1;
            din_q2 = ~vecs[i].q2;
            din_or = ~vecs[i].orf;
            tick();
            start_cap(16'd1);
            din_q1 = vecs[i].q1;
            din_q2 = vecs[i].q2;
            din_or = vecs[i].orf;
            check($sformatf("v%0d_busy", i), busy, 1);
            n = 0;
            while (!m_tvalid && n < 50) begin
                tick();
                n++;
            end
            check($sformatf("v%0d_latency", i), n, 6);
            check($sformatf("v%0d_main", i), m_tdata, rep4(vecs[i].e_main));
            check($sformatf("v%0d_twos_swap", i), tw_tdata, rep4(vecs[i].e_tw));
            check($sformatf("v%0d_offset_swap", i), of_tdata, rep4(vecs[i].e_of));
            check($sformatf("v%0d_tlast", i), m_tlast, 1);
            m_tready = 1'b1;
            wait_done($sformatf("v%0d", i));
            check($sformatf("v%0d_idle", i), busy, 0);
            tick();
        end

        din_q1 = 6'h2A;
        din_q2 = 6'h15;
        din_or = 1'b0;

        // Basic packing with continuous ready
        m_tready = 1'b1;
        w0 = acc_words; t0 = tlast_seen; d0 = done_seen;
        start_cap(16'd2);
        wait_done("basic");
        tick();
        check("basic_words", acc_words - w0, 2);
        check("basic_tlast_cnt", tlast_seen - t0, 1);
        check("basic_tlast_final", last_tlast, 1);
        check("basic_data", last_word, 64'h0A95_0A95_0A95_0A95);
        check("basic_gap", acc_gap, 4);
        check("basic_done_cnt", done_seen - d0, 1);
        check("basic_done_pulse", done, 0);
        check("basic_ovf_cnt", overflow_cnt, 0);

        // Back-pressure: 5 words into a stalled 2-entry buffer
        m_tready = 1'b0;
        w0 = acc_words; t0 = tlast_seen; d0 = done_seen;
        start_cap(16'd5);
        repeat (24) tick();
        check("bp_overflow", overflow, 1);
        check("bp_ovf_cnt", overflow_cnt, 3);
        check("bp_tvalid", m_tvalid, 1);
        check("bp_busy", busy, 1);
        m_tready = 1'b1;
        wait_done("bp");
        tick();
        check("bp_words", acc_words - w0, 2);
        check("bp_tlast_cnt", tlast_seen - t0, 0);
        check("bp_done_cnt", done_seen - d0, 1);

        // Read and write together on a full buffer
        m_tready = 1'b0;
        w0 = acc_words; t0 = tlast_seen;
        start_cap(16'd3);
        repeat (13) tick();
        m_tready = 1'b1;
        wait_done("rw");
        tick();
        check("rw_ovf_cnt", overflow_cnt, 0);
        check("rw_overflow", overflow, 0);
        check("rw_words", acc_words - w0, 3);
        check("rw_tlast_cnt", tlast_seen - t0, 1);

        // Reset in the middle of a capture that has already dropped a word
        m_tready = 1'b0;
        start_cap(16'd6);
        repeat (16) tick();
        check("mid_pre_ovf_cnt", overflow_cnt, 1);
        check("mid_pre_busy", busy, 1);
        rst = 1'b1;
        tick();
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        tick();

        // Second start while busy is ignored
        m_tready = 1'b1;
        w0 = acc_words; t0 = tlast_seen; d0 = done_seen;
        start_cap(16'd2);
        repeat (3) tick();
        start_cap(16'd5);
        wait_done("restart");
        tick();
        check("restart_words", acc_words - w0, 2);
        check("restart_tlast_cnt", tlast_seen - t0, 1);
        check("restart_done_cnt", done_seen - d0, 1);
        check("restart_idle", busy, 0);

        // Zero-length request
        w0 = acc_words; d0 = done_seen;
        start_cap(16'd0);
        check("zero_busy", busy, 0);
        repeat (10) tick();
        check("zero_busy_late", busy, 0);
        check("zero_tvalid", m_tvalid, 0);
        check("zero_words", acc_words - w0, 0);
        check("zero_done_cnt", done_seen - d0, 0);

        check("done_with_busy", done_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ad9434_sample_pack.md
# ad9434_sample_pack

Sits directly downstream of the AD9434 DDR capture stage, in the `adc_clk` domain. It takes the registered 6-bit rising-edge and falling-edge IDDR lanes plus the over-range bit and assembles them into 12-bit samples. It packs four samples per 64-bit word and emits a length-bounded capture on a valid/ready stream. The ADC cannot be stalled, so the block absorbs downstream back-pressure in a 2-entry buffer, drops words on overflow and counts the drops.

## Interface
Parameters:
- `DATA_FORMAT`, "OFFSET": "OFFSET" passes offset-binary samples through; "TWOS" inverts bit 11 to give two's complement.
- `LANE_SWAP`, 0:
  - 0: sample[11:6] = `din_q1`, sample[5:0] = `din_q2`.
  - 1: the halves are exchanged.
- `LEN_W`, 16: width of `capture_len` and `overflow_cnt`.

Ports:
- `adc_clk` in 1: the single clock (DCO-derived). One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `din_q1` in 6: rising-edge lane data.
- `din_q2` in 6: falling-edge lane data.
- `din_or` in 1: ADC over-range flag.
- `capture_start` in 1: single-cycle start request; honoured only in IDLE.
- `capture_len` in LEN_W: number of 64-bit words to capture; latched on start.
- `m_tdata` out 64: four samples; sample 0 in [15:0], sample 3 in [63:48].
- `m_tvalid` out 1: output word valid.
- `m_tready` in 1: downstream accept.
- `m_tlast` out 1: marks the final word of the capture.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when the capture completes.
- `overflow` out 1: sticky flag; set when any word has been dropped in the current capture.
- `overflow_cnt` out LEN_W: number of dropped words; saturates at all-ones.

## Operation
- **Input stage**: `din_q1`, `din_q2` and `din_or` are registered every cycle, unconditionally.
- **Format stage**: 12-bit sample assembly per `LANE_SWAP` and `DATA_FORMAT`. Each sample is extended to a 16-bit lane:
  - [15] = or flag;
  - [14:12] = sign extension of bit 11 in "TWOS" mode, 3'b000 in "OFFSET" mode;
  - [11:0] = sample.
- **State machine**:
  - **IDLE**: on `capture_start`=1 with `capture_len`≠0, latch the length, clear `overflow` and `overflow_cnt`, zero the slot and word counters, and go to CAPTURE. With `capture_len`=0 the request is ignored and the block stays in IDLE with no `done`.
  - **CAPTURE**: each formatted sample fills slot 0..3; the slot counter wraps 3→0. On slot 3 a word is generated and the word counter increments. When the word counter reaches the latched length, the last word is tagged with `tlast` and the state goes to DRAIN. Samples are packed only in CAPTURE.
  - **DRAIN**: wait until the buffer is empty, then pulse `done` for one cycle and go to IDLE.
- **Output buffer**: 2-entry FIFO carrying {tlast, data}; the head drives `m_tdata`/`m_tlast`, and `m_tvalid` = not empty.
  - Write while full with `m_tready`=1 in the same cycle: the read and the write both succeed.
  - Write while full with `m_tready`=0: the new word is dropped, `overflow` is set and `overflow_cnt` increments (saturating).
  - Dropped words still count toward `capture_len`. If the tlast word is dropped, DRAIN still ends on empty and `done` still pulses.
- `capture_start` while `busy` is ignored.
- `m_tdata`/`m_tlast` hold while `m_tvalid`=1 and `m_tready`=0.

## Timing
- Reset values: `m_tvalid`=0, `m_tdata`=0, `m_tlast`=0, `busy`=0, `done`=0, `overflow`=0, `overflow_cnt`=0, state IDLE, buffer empty. The same values apply from the edge after `rst` is sampled high, including mid-capture; in-flight words are discarded.
- Start is sampled at edge k, and `busy`=1 after edge k.
- Capture alignment: sample 0 is the input presented at edge k+1. The pipeline delay is matched, so no stale pre-start data is packed.
- Latency: the word containing samples 0-3 (inputs at edges k+1..k+4) has `m_tvalid`=1 after edge k+6. In general, the first word is valid 2 cycles after the edge that registers its 4th sample.
- With `m_tready` held at 1, throughput is one word every 4 cycles with no drops.
- `done` is asserted for the cycle after the edge at which the last buffered word is accepted; `busy` falls together with `done`.

## Test plan
- **Basic packing**:
  - Stimulus: reset; OFFSET, LANE_SWAP=0; `capture_len`=2; `din_q1`=0x2A, `din_q2`=0x15 constant, or=0; `m_tready`=1.
  - Response: two words of 0x0A95_0A95_0A95_0A95; `m_tlast` only on the second; `done` pulse; `overflow_cnt`=0.
- **Format and swap**:
  - Stimulus: TWOS, LANE_SWAP=1; `din_q1`=0x00, `din_q2`=0x3F, or=1.
  - Response: sample 0xFC0 → bit 11 inverted gives 0x7C0 → lane 0x87C0.
  - Stimulus: OFFSET with the same inputs.
  - Response: lane 0x8FC0.
- **Back-pressure drop**:
  - Stimulus: `capture_len`=5; `m_tready`=0 until all 5 words are generated, then 1.
  - Response: words 1-2 delivered, 3 dropped, `overflow`=1, `overflow_cnt`=3, no `m_tlast` seen, `done` pulses after the buffer empties.
- **Simultaneous read and write on full buffer**:
  - Stimulus: `m_tready` toggles so that it is 1 in the cycle word 3 arrives while the buffer is full.
  - Response: no drop, `overflow_cnt`=0.
- **Mid-operation reset and ignored start**:
  - Stimulus: `rst` asserted mid-CAPTURE.
  - Response: all outputs return to reset values the next cycle.
  - Stimulus: a new capture started, then `capture_start` asserted again while `busy`.
  - Response: the second start is ignored; the word count matches the original length.
- **Zero length**:
  - Stimulus: `capture_len`=0 with `capture_start`.
  - Response: `busy` stays 0, no `m_tvalid`, no `done`.
